// File: rtl/demux_pkg.sv
// Shared constants and types for the buffered 1:31 demultiplexer.
package demux_pkg;

    localparam int DW    = 2;   // payload width per lane
    localparam int SW    = 5;   // select width
    localparam int N_OUT = 31;  // number of output lanes

    // First select value that does not address a lane.
    localparam logic [SW-1:0] SEL_INVALID = 5'd31;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_t;

    // True when the select addresses a real lane.
    function automatic logic sel_in_range(input logic [SW-1:0] sel);
        return sel < SEL_INVALID;
    endfunction

endpackage

// File: rtl/demux_lane.sv
// One-entry output buffer for a single demux lane.
// The lane is loaded by the top only when it is EMPTY or being popped in the
// same cycle, so a load never overwrites data the consumer has not taken.
module demux_lane
    import demux_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] data
);

    lane_state_t   state_q, state_d;
    logic [DW-1:0] data_q, data_d;

    // Next-state and next-data: fill on load, drain on pop without load.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            LANE_EMPTY: begin
                if (load) begin
                    state_d = LANE_FULL;
                end
            end
            LANE_FULL: begin
                if (pop && !load) begin
                    state_d = LANE_EMPTY;
                end
            end
            default: begin
                state_d = LANE_EMPTY;
            end
        endcase
        if (load) begin
            data_d = load_data;
        end
    end

    // Lane state and payload registers; reset empties the lane and clears data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LANE_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid = (state_q == LANE_FULL);
    assign data  = data_q;

endmodule

// File: rtl/demux_buffered.sv
// Buffered 1:31 demultiplexer: routes a 2-bit stream to one of 31 lanes,
// each holding one entry behind a valid/ready handshake.
// Optional feature: define DEMUX_ERR_CNT_EN to add err_cnt, a saturating
// count of accepts that carried an out-of-range select.
module demux_buffered
    import demux_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SW-1:0]       in_sel,
    input  logic [DW-1:0]       in_data,
    output logic [N_OUT-1:0]    out_valid,
    input  logic [N_OUT-1:0]    out_ready,
    output logic [N_OUT*DW-1:0] out_data,
    output logic                err_sel
`ifdef DEMUX_ERR_CNT_EN
    ,
    output logic [7:0]          err_cnt
`endif
);

    logic             sel_ok;
    logic             sel_ready;
    logic             accept;
    logic [N_OUT-1:0] load_vec;
    logic             err_sel_q, err_sel_d;

    // Select decode: pick the addressed lane's readiness and steer the load.
    // An out-of-range select is always ready so the producer is never stuck;
    // its data is simply dropped and flagged.
    always_comb begin
        sel_ok    = sel_in_range(in_sel);
        sel_ready = 1'b1;
        load_vec  = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (in_sel == SW'(i)) begin
                sel_ready = !out_valid[i] || out_ready[i];
            end
        end
        accept = in_valid && sel_ready;
        for (int i = 0; i < N_OUT; i++) begin
            load_vec[i] = accept && (in_sel == SW'(i));
        end
        err_sel_d = accept && !sel_ok;
    end

    assign in_ready = sel_ready;

    // One buffer per lane; the consumer's ready doubles as the pop strobe.
    for (genvar g = 0; g < N_OUT; g++) begin : g_lane
        demux_lane u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      (load_vec[g]),
            .load_data (in_data),
            .pop       (out_ready[g]),
            .valid     (out_valid[g]),
            .data      (out_data[g*DW +: DW])
        );
    end

    // Error pulse register: high for exactly the cycle after a bad-select accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sel_q <= 1'b0;
        end else begin
            err_sel_q <= err_sel_d;
        end
    end

    assign err_sel = err_sel_q;

`ifdef DEMUX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating bad-select counter: sticks at 255 rather than wrapping.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_sel_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_demux_buffered.sv
// Self-checking bench for demux_buffered: per-lane scoreboard queues plus
// scenario tasks for reset, routing, backpressure, sweep, invalid select and
// random back-to-back traffic.
module tb_demux_buffered;

    localparam int NL = 31;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_sel;
    logic [1:0]       in_data;
    logic [NL-1:0]    out_valid;
    logic [NL-1:0]    out_ready;
    logic [NL*2-1:0]  out_data;
    logic             err_sel;
`ifdef DEMUX_ERR_CNT_EN
    logic [7:0]       err_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0] exp_q [NL][$];
    int         pop_cnt [NL];
    logic       exp_err = 1'b0;
    logic       mon_rdy;
    logic       mon_v;
    int         mon_idx;

    demux_buffered dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_sel   (err_sel)
`ifdef DEMUX_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: checks every lane, in_ready and err_sel on the
    // falling edge, then applies the pops/pushes the next rising edge will do.
    always @(negedge clk) begin
        if (!rst) begin
            mon_idx = int'(in_sel);
            mon_rdy = 1'b1;
            if (mon_idx < NL) begin
                mon_rdy = (exp_q[mon_idx].size() == 0) || out_ready[mon_idx];
            end
            n_cmp++;
            if (in_ready !== mon_rdy) begin
                n_err++;
                $display("FAIL mon_in_ready sel=%0d got %b exp %b", in_sel, in_ready, mon_rdy);
            end
            n_cmp++;
            if (err_sel !== exp_err) begin
                n_err++;
                $display("FAIL mon_err_sel got %b exp %b", err_sel, exp_err);
            end
            for (int i = 0; i < NL; i++) begin
                mon_v = (exp_q[i].size() != 0);
                n_cmp++;
                if (out_valid[i] !== mon_v) begin
                    n_err++;
                    $display("FAIL mon_lane%0d_valid got %b exp %b", i, out_valid[i], mon_v);
                end
                if (mon_v) begin
                    n_cmp++;
                    if (out_data[i*2 +: 2] !== exp_q[i][0]) begin
                        n_err++;
                        $display("FAIL mon_lane%0d_data got %b exp %b", i, out_data[i*2 +: 2], exp_q[i][0]);
                    end
                    if (out_ready[i]) begin
                        void'(exp_q[i].pop_front());
                        pop_cnt[i]++;
                    end
                end
            end
            exp_err = 1'b0;
            if (in_valid && mon_rdy) begin
                if (mon_idx < NL) exp_q[mon_idx].push_back(in_data);
                else exp_err = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and hold it until accepted (bounded).
    task automatic send(input logic [4:0] s, input logic [1:0] d);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL send_timeout sel=%0d got no accept exp accept", s);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NL; i++) exp_q[i].delete();
        exp_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
        tick(); tick();
        n_cmp++;
        if (out_valid !== '0 || out_data !== '0 || err_sel !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init got v=%h d=%h e=%b exp 0", out_valid, out_data, err_sel);
        end
        rst = 1'b0;
        tick();
        // Fill two lanes and leave an error pulse pending, then reset mid-cycle.
        send(5'd5, 2'b01);
        send(5'd7, 2'b10);
        send(5'd31, 2'b11);
        n_cmp++;
        if (out_valid[5] !== 1'b1 || out_valid[7] !== 1'b1 || err_sel !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre got v5=%b v7=%b e=%b exp 1 1 1", out_valid[5], out_valid[7], err_sel);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== '0 || out_data !== '0 || err_sel !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid got v=%h d=%h e=%b exp 0", out_valid, out_data, err_sel);
        end
        clear_model();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_route();
        out_ready = '0;
        out_ready[12] = 1'b1;
        send(5'd12, 2'b10);
        n_cmp++;
        if (out_valid !== (31'd1 << 12)) begin
            n_err++;
            $display("FAIL route_valid got %h exp %h", out_valid, 31'd1 << 12);
        end
        n_cmp++;
        if (out_data[25:24] !== 2'b10) begin
            n_err++;
            $display("FAIL route_data got %b exp 10", out_data[25:24]);
        end
        tick();
        out_ready = '0;
    endtask

    task automatic test_backpressure();
        out_ready = '0;
        send(5'd3, 2'b01);
        in_valid = 1'b1; in_sel = 5'd3; in_data = 2'b10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid[3] !== 1'b1 || out_data[7:6] !== 2'b01) begin
                n_err++;
                $display("FAIL bp_stall got rdy=%b v=%b d=%b exp 0 1 01", in_ready, out_valid[3], out_data[7:6]);
            end
            tick();
        end
        out_ready[3] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release got %b exp 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        out_ready[3] = 1'b0;
        n_cmp++;
        if (out_valid[3] !== 1'b1 || out_data[7:6] !== 2'b10) begin
            n_err++;
            $display("FAIL bp_reload got v=%b d=%b exp 1 10", out_valid[3], out_data[7:6]);
        end
        tick();
        out_ready[3] = 1'b1;
        tick();
        out_ready = '0;
    endtask

    task automatic test_sweep();
        out_ready = '1;
        for (int i = 0; i < NL; i++) pop_cnt[i] = 0;
        for (int s = 0; s < NL; s++) begin
            send(5'(s), 2'(s));
            n_cmp++;
            if (err_sel !== 1'b0) begin
                n_err++;
                $display("FAIL sweep_err sel=%0d got %b exp 0", s, err_sel);
            end
        end
        tick(); tick();
        for (int i = 0; i < NL; i++) begin
            n_cmp++;
            if (pop_cnt[i] != 1) begin
                n_err++;
                $display("FAIL sweep_pops lane%0d got %0d exp 1", i, pop_cnt[i]);
            end
        end
        out_ready = '0;
    endtask

    task automatic test_invalid();
        logic [NL-1:0] snap;
        out_ready = '0;
        send(5'd4, 2'b11);
        snap = out_valid;
        in_valid = 1'b1; in_sel = 5'd31; in_data = 2'b01;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL inv_ready got %b exp 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (err_sel !== 1'b1 || out_valid !== snap || out_data[9:8] !== 2'b11) begin
            n_err++;
            $display("FAIL inv_pulse got e=%b v=%h d=%b exp 1 %h 11", err_sel, out_valid, out_data[9:8], snap);
        end
`ifdef DEMUX_ERR_CNT_EN
        n_cmp++;
        if (err_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL inv_cnt1 got %0d exp 1", err_cnt);
        end
`endif
        tick();
        n_cmp++;
        if (err_sel !== 1'b0) begin
            n_err++;
            $display("FAIL inv_clear got %b exp 0", err_sel);
        end
`ifdef DEMUX_ERR_CNT_EN
        for (int k = 0; k < 300; k++) send(5'd31, 2'(k));
        tick();
        n_cmp++;
        if (err_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL inv_cnt_sat got %0d exp 255", err_cnt);
        end
`endif
        out_ready = '1;
        tick();
        out_ready = '0;
    endtask

    task automatic test_back_to_back();
        bit acc = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            out_ready = 31'($urandom);
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 5'($urandom_range(0, 31));
                in_data  = 2'($urandom);
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = '1;
        tick(); tick();
        n_cmp++;
        if (out_valid !== '0) begin
            n_err++;
            $display("FAIL b2b_drain got %h exp 0", out_valid);
        end
        out_ready = '0;
    endtask

    initial begin
        test_reset();
        test_route();
        test_backpressure();
        test_sweep();
        test_invalid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
